// File: rtl/former_spad_seq_pkg.sv
// ----------------------------------------------------------------------------
// former_spad_seq_pkg
//   Shared definitions for the former data spad and its sequencers:
//   - sequencer state encoding
//   - spad word layout: {data[12:5], count[4:0]}, all-zero word = end marker
//   - small helpers for field extraction and pass-count normalisation
// ----------------------------------------------------------------------------
package former_spad_seq_pkg;

    // Spad word layout
    localparam int unsigned SPAD_DATA_W   = 8;
    localparam int unsigned SPAD_CNT_W    = 5;
    localparam int unsigned SPAD_DATA_LSB = SPAD_CNT_W;
    localparam int unsigned SPAD_WORD_W   = SPAD_DATA_W + SPAD_CNT_W;

    // Replay pass counter width
    localparam int unsigned PASS_W = 8;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PRIME = 3'd3,
        ST_READ  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    function automatic logic [SPAD_DATA_W-1:0] spad_word_data(
        input logic [SPAD_WORD_W-1:0] w
    );
        return w[SPAD_WORD_W-1:SPAD_DATA_LSB];
    endfunction

    function automatic logic [SPAD_CNT_W-1:0] spad_word_count(
        input logic [SPAD_WORD_W-1:0] w
    );
        return w[SPAD_CNT_W-1:0];
    endfunction

    function automatic logic spad_word_is_end(
        input logic [SPAD_WORD_W-1:0] w
    );
        return (w == '0);
    endfunction

    // A requested pass count of zero still replays the vector once.
    function automatic logic [PASS_W-1:0] norm_passes(
        input logic [PASS_W-1:0] p
    );
        return (p == '0) ? PASS_W'(1) : p;
    endfunction

endpackage : former_spad_seq_pkg

// File: rtl/former_spad_seq_pass_counter.sv
// ----------------------------------------------------------------------------
// former_spad_seq_pass_counter
//   Replay pass counter with synchronous clear, increment and a
//   terminal-count flag.
//
//   clock   in   clock
//   reset   in   synchronous active-high reset (count -> 0)
//   clr_i   in   clear count to 0 (wins over inc_i)
//   inc_i   in   increment count by one
//   limit_i in   number of passes to run (expected >= 1)
//   last_o  out  high when the next increment reaches limit_i, i.e. the
//                pass currently ending is the final one
// ----------------------------------------------------------------------------
module former_spad_seq_pass_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] limit_i,
    output logic         last_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_plus1;

    assign cnt_plus1 = cnt_q + ONE;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_plus1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Equality against the limit; limit never exceeds 2^W-1, so no wrap.
    assign last_o = (cnt_plus1 == limit_i);

endmodule : former_spad_seq_pass_counter

// File: rtl/former_spad_seq.sv
// ----------------------------------------------------------------------------
// former_spad_seq
//   Per-PE sequencer for the former data spad. After reset it waits out the
//   spad's BRAM clear, then on a start request runs a load phase (spad
//   write enable until the spad reports the terminator written), primes the
//   BRAM read, and replays the stored compressed vector to the MAC as a
//   valid/ready stream for a configurable number of passes.
//
//   clock           in   clock
//   reset           in   synchronous active-high reset
//   cfg_start       in   pulse: begin load then replay
//   cfg_passes      in   replay pass count (0 behaves as 1)
//   spad_write_en   out  spad write enable during load
//   spad_write_fin  in   spad reports terminator written
//   spad_index_inc  out  advance spad read address
//   spad_data_out   in   spad read word {data, count}; all-zero = end marker
//   mac_valid       out  word presented to MAC
//   mac_ready       in   MAC accepts presented word
//   mac_data        out  data field of presented word
//   mac_count       out  count field of presented word
//   mac_pass_end    out  pulse: end marker consumed, pass complete
//   busy            out  high in every state except IDLE
//   done            out  one-cycle pulse after the final pass
// ----------------------------------------------------------------------------
module former_spad_seq
    import former_spad_seq_pkg::*;
#(
    parameter int unsigned CLEAR_CYCLES = 100,
    parameter int unsigned DATA_W       = SPAD_DATA_W,
    parameter int unsigned CNT_W        = SPAD_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic [PASS_W-1:0]       cfg_passes,
    output logic                    spad_write_en,
    input  logic                    spad_write_fin,
    output logic                    spad_index_inc,
    input  logic [DATA_W+CNT_W-1:0] spad_data_out,
    output logic                    mac_valid,
    input  logic                    mac_ready,
    output logic [DATA_W-1:0]       mac_data,
    output logic [CNT_W-1:0]        mac_count,
    output logic                    mac_pass_end,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned WORD_W = DATA_W + CNT_W;
    localparam int unsigned CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);

    seq_state_t        state_q, state_d;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              pending_q, pending_d;
    logic [PASS_W-1:0] passes_q, passes_d;

    logic              pc_clr;
    logic              pc_inc;
    logic              pc_last;
    logic              word_end;

    assign word_end = (spad_data_out == '0);

    former_spad_seq_pass_counter #(
        .W (PASS_W)
    ) u_pass_counter (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (pc_clr),
        .inc_i   (pc_inc),
        .limit_i (passes_q),
        .last_o  (pc_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            pending_q <= 1'b0;
            passes_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            pending_q <= pending_d;
            passes_q  <= passes_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        pending_d      = pending_q;
        passes_d       = passes_q;
        pc_clr         = 1'b0;
        pc_inc         = 1'b0;
        spad_write_en  = 1'b0;
        spad_index_inc = 1'b0;
        mac_valid      = 1'b0;
        mac_pass_end   = 1'b0;
        done           = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + CLR_ONE;
                // A start arriving while the BRAM is still clearing is
                // remembered and replayed on the first IDLE cycle.
                if (cfg_start) begin
                    pending_d = 1'b1;
                    passes_d  = norm_passes(cfg_passes);
                end
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    pc_clr    = 1'b1;
                    state_d   = ST_LOAD;
                end else if (cfg_start) begin
                    passes_d  = norm_passes(cfg_passes);
                    pc_clr    = 1'b1;
                    state_d   = ST_LOAD;
                end
            end

            ST_LOAD: begin
                spad_write_en = 1'b1;
                if (spad_write_fin) begin
                    state_d = ST_PRIME;
                end
            end

            // One quiet cycle so the BRAM output reflects the read address.
            ST_PRIME: begin
                state_d = ST_READ;
            end

            ST_READ: begin
                if (!word_end) begin
                    mac_valid      = 1'b1;
                    spad_index_inc = mac_ready;
                end else begin
                    // Advancing past the marker wraps the spad read address.
                    spad_index_inc = 1'b1;
                    mac_pass_end   = 1'b1;
                    pc_inc         = 1'b1;
                    if (pc_last) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign mac_data  = mac_valid ? spad_data_out[WORD_W-1:CNT_W] : '0;
    assign mac_count = mac_valid ? spad_data_out[CNT_W-1:0]      : '0;

endmodule : former_spad_seq

// File: tb/tb_former_spad_seq.sv
// ----------------------------------------------------------------------------
// tb_former_spad_seq
//   Randomised scoreboard bench for former_spad_seq. A small spad model with
//   one-cycle read latency and end-marker wrap sits between the DUT and the
//   stimulus; expected MAC events are derived from the loaded vector and the
//   pass count and compared in order by a negedge monitor.
// ----------------------------------------------------------------------------
module tb_former_spad_seq;

    localparam int K_BEAT = 0;
    localparam int K_PEND = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        logic [12:0] word;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        cfg_start;
    logic [7:0]  cfg_passes;
    logic        spad_write_en;
    logic        spad_write_fin;
    logic        spad_index_inc;
    logic [12:0] spad_data_out;
    logic        mac_valid;
    logic        mac_ready;
    logic [7:0]  mac_data;
    logic [4:0]  mac_count;
    logic        mac_pass_end;
    logic        busy;
    logic        done;

    former_spad_seq #(
        .CLEAR_CYCLES (100),
        .DATA_W       (8),
        .CNT_W        (5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_passes     (cfg_passes),
        .spad_write_en  (spad_write_en),
        .spad_write_fin (spad_write_fin),
        .spad_index_inc (spad_index_inc),
        .spad_data_out  (spad_data_out),
        .mac_valid      (mac_valid),
        .mac_ready      (mac_ready),
        .mac_data       (mac_data),
        .mac_count      (mac_count),
        .mac_pass_end   (mac_pass_end),
        .busy           (busy),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rdy_mode = 0;
    exp_t exp_q[$];
    logic [12:0] cur_vec[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic flag_fail(input string nm, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got 0x%0h, expected no such event (cycle %0d)", nm, act, cyc);
    endtask

    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    // ------------------------------------------------------------------
    // Spad model: upstream writes the current vector plus terminator while
    // write_en is high, reports fin the cycle after the terminator lands.
    // Reads are registered off the next read address; advancing from the
    // end marker wraps the address to 0.
    // ------------------------------------------------------------------
    logic [12:0] mem      [0:63];
    logic [12:0] load_vec [0:63];
    int          rd, rd_nxt, wr;
    logic        term;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]      = '0;
            load_vec[i] = '0;
        end
    end

    always_comb begin
        rd_nxt = rd;
        if (spad_index_inc) rd_nxt = (spad_data_out == 13'd0) ? 0 : rd + 1;
    end

    always @(posedge clock) begin
        if (reset) begin
            rd             <= 0;
            wr             <= 0;
            term           <= 1'b0;
            spad_write_fin <= 1'b0;
            spad_data_out  <= '0;
        end else begin
            rd             <= rd_nxt;
            spad_data_out  <= mem[rd_nxt];
            spad_write_fin <= 1'b0;
            if (spad_write_en && !term) begin
                mem[wr] <= load_vec[wr];
                wr      <= wr + 1;
                if (load_vec[wr] == 13'd0) begin
                    term           <= 1'b1;
                    spad_write_fin <= 1'b1;
                end
            end else if (!spad_write_en) begin
                wr   <= 0;
                term <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ready driver
    // ------------------------------------------------------------------
    initial begin
        mac_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       mac_ready = 1'b1;
                1:       mac_ready = ~mac_ready;
                default: mac_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int          done_cnt  = 0;
    int          pe_cyc    = -10;
    logic        hold_pend = 1'b0;
    logic [12:0] hold_word = '0;

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(mac_valid), 32'd1);
                check("hold_word", 32'({mac_data, mac_count}), 32'(hold_word));
            end
            hold_pend <= mac_valid && !mac_ready;
            hold_word <= {mac_data, mac_count};

            if (spad_write_en || spad_index_inc)
                check("wen_inc_exclusive", 32'(spad_write_en & spad_index_inc), 32'd0);
            if (mac_valid)
                check("index_inc_on_accept", 32'(spad_index_inc), 32'(mac_ready));
            if (!mac_valid && !mac_pass_end && spad_index_inc)
                flag_fail("stray_index_inc", 32'(spad_index_inc));

            if (mac_valid && mac_ready) begin
                if (exp_q.size() == 0) flag_fail("unexpected_beat", 32'({mac_data, mac_count}));
                else begin
                    e = exp_q.pop_front();
                    check("beat_kind", K_BEAT, e.kind);
                    check("beat_word", 32'({mac_data, mac_count}), 32'(e.word));
                end
            end
            if (mac_pass_end) begin
                check("pass_end_no_valid", 32'(mac_valid), 32'd0);
                pe_cyc <= cyc;
                if (exp_q.size() == 0) flag_fail("unexpected_pass_end", 32'd1);
                else begin
                    e = exp_q.pop_front();
                    check("pass_end_kind", K_PEND, e.kind);
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                check("done_latency", cyc, pe_cyc + 1);
                if (exp_q.size() == 0) flag_fail("unexpected_done", 32'd1);
                else begin
                    e = exp_q.pop_front();
                    check("done_kind", K_DONE, e.kind);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_vec();
        for (int i = 0; i < cur_vec.size(); i++) load_vec[i] = cur_vec[i];
        load_vec[cur_vec.size()] = 13'd0;
    endtask

    // Reference: every pass streams the nonzero words in order then ends.
    task automatic push_expect(input int passes);
        int p;
        exp_t e;
        p = (passes == 0) ? 1 : passes;
        for (int k = 0; k < p; k++) begin
            foreach (cur_vec[i]) begin
                e.kind = K_BEAT;
                e.word = cur_vec[i];
                exp_q.push_back(e);
            end
            e.kind = K_PEND;
            e.word = '0;
            exp_q.push_back(e);
        end
        e.kind = K_DONE;
        e.word = '0;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int passes);
        @(posedge clock);
        #1;
        cfg_start  = 1'b1;
        cfg_passes = 8'(passes);
        @(posedge clock);
        #1;
        cfg_start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            if (done_cnt != d0) break;
        end
        if (done_cnt == d0) begin
            flag_fail("done_timeout", 32'(exp_q.size()));
            exp_q.delete();
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        @(negedge clock);
        check("rst_write_en", 32'(spad_write_en), 32'd0);
        check("rst_index_inc", 32'(spad_index_inc), 32'd0);
        check("rst_mac_valid", 32'(mac_valid), 32'd0);
        check("rst_mac_data", 32'(mac_data), 32'd0);
        check("rst_mac_count", 32'(mac_count), 32'd0);
        check("rst_pass_end", 32'(mac_pass_end), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
    endtask

    // Called with reset high: releases reset, pulses start in cycle 10 of
    // the clear window, and checks that loading begins right after it.
    task automatic run_clear_start(input int passes);
        int first_we;
        @(posedge clock);
        #1;
        reset = 1'b0;
        set_vec();
        push_expect(passes);
        while (cyc < 10) begin
            @(posedge clock);
            #1;
        end
        cfg_start  = 1'b1;
        cfg_passes = 8'(passes);
        @(posedge clock);
        #1;
        cfg_start  = 1'b0;
        first_we   = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (cyc == 100) check("idle_at_clear_end", 32'(busy), 32'd0);
            if (spad_write_en) begin
                first_we = cyc;
                break;
            end
        end
        check("first_write_en_cycle", first_we, 101);
        wait_done(1000);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        reset      = 1'b1;
        cfg_start  = 1'b0;
        cfg_passes = '0;
        rdy_mode   = 0;
        repeat (3) @(posedge clock);
        check_reset_outputs();

        // Start during clear, 3-word vector, two passes, MAC always ready
        cur_vec = '{13'h0A1, 13'h142, 13'h1E3};
        run_clear_start(2);

        // Same vector, ready alternating, plus a start while busy
        rdy_mode = 1;
        set_vec();
        push_expect(2);
        pulse_start(2);
        repeat (4) @(posedge clock);
        #1;
        cfg_start  = 1'b1;
        cfg_passes = 8'd7;
        @(posedge clock);
        #1;
        cfg_start  = 1'b0;
        wait_done(500);

        // passes = 0 behaves as a single pass
        rdy_mode = 0;
        set_vec();
        push_expect(0);
        pulse_start(0);
        wait_done(500);

        // Empty vector, three passes
        rdy_mode = 2;
        cur_vec.delete();
        set_vec();
        push_expect(3);
        pulse_start(3);
        wait_done(500);

        // Randomised jobs
        for (int j = 0; j < 10; j++) begin
            int n;
            int p;
            n = int'($urandom_range(0, 6));
            p = int'($urandom_range(0, 4));
            rdy_mode = int'($urandom_range(0, 2));
            cur_vec.delete();
            for (int i = 0; i < n; i++) cur_vec.push_back(13'($urandom_range(1, 8191)));
            set_vec();
            push_expect(p);
            pulse_start(p);
            wait_done(2000);
        end

        // Reset in the middle of replay, then a fresh start from clear
        rdy_mode = 0;
        cur_vec = '{13'h011, 13'h1FF, 13'h0C3, 13'h1000, 13'h007};
        set_vec();
        push_expect(4);
        pulse_start(4);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clock);
                if (mac_valid) begin
                    seen = 1;
                    break;
                end
            end
            check("replay_started", seen, 1);
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        exp_q.delete();
        check_reset_outputs();
        cur_vec = '{13'h0A1, 13'h142, 13'h1E3};
        run_clear_start(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_former_spad_seq

// File: doc/former_spad_seq.md
Name: former_spad_seq

Overview:
- Per-PE sequencer for the former data spad (weights for CONV; iacts for DW-CONV/FC).
- Waits out the spad's post-reset BRAM clear, then runs a load phase, then replays the stored compressed vector to the MAC datapath a configurable number of passes.
- Drives the spad's write_en/index_inc, absorbs the 1-cycle BRAM read latency, and presents a valid/ready stream to the MAC.

Parameters:
- CLEAR_CYCLES, 100, cycles after reset deassertion before a load may begin (spad BRAM clear time).
- DATA_W, 8, data field width of the spad word.
- CNT_W, 5, count field width of the spad word.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cfg_start  in  1  pulse: begin load then replay
- cfg_passes  in  8  replay pass count, sampled on accepted start; 0 treated as 1
- spad_write_en  out  1  spad write enable (load phase)
- spad_write_fin  in  1  spad reports the zero terminator was written
- spad_index_inc  out  1  spad read advance
- spad_data_out  in  13  spad read word; data=[12:5], count=[4:0]; all-zero = end marker
- mac_valid  out  1  word available to MAC
- mac_ready  in  1  MAC accepts word
- mac_data  out  8  spad_data_out[12:5]
- mac_count  out  5  spad_data_out[4:0]
- mac_pass_end  out  1  pulse: end marker consumed, pass complete
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after final pass

Behaviour:
- States: CLEAR, IDLE, LOAD, PRIME, READ, DONE. Reset → CLEAR, clear counter=0, pass counter=0, start_pending=0.
- Reset values: all outputs 0, except busy=1 (state is CLEAR).
- CLEAR: counter increments each cycle. At CLEAR_CYCLES-1 → IDLE.
  - cfg_start seen in CLEAR sets start_pending, together with cfg_passes.
  - start_pending is honoured on entry to IDLE: the IDLE → LOAD transition is taken in the first IDLE cycle.
- IDLE: cfg_start (or start_pending) → LOAD. Latch passes; 0 is stored as 1. Clear pass counter.
- LOAD: spad_write_en=1. spad_write_fin=1 → PRIME. Upstream data goes directly to the spad; this block only observes fin.
- PRIME: exactly 1 cycle with write_en=0 and index_inc=0, so the BRAM re-reads the read address → READ.
- READ, word≠0:
  - mac_valid=1.
  - spad_index_inc = mac_valid & mac_ready, same cycle (combinational).
  - The next word is valid the following cycle; no bubble in steady state.
  - mac_ready low: hold, index_inc=0, word stable.
- READ, word=0:
  - mac_valid=0, spad_index_inc=1 (spad wraps its read address to 0), mac_pass_end=1, pass counter +1.
  - If this was the last pass → DONE, else stay in READ. The next cycle presents word 0 of the vector.
- Empty vector (first word 0): each pass takes 1 cycle; no mac_valid at all.
- DONE: done=1 for one cycle → IDLE.
- cfg_start while busy and not in CLEAR: ignored.
- spad_index_inc and spad_write_en are never both high, and index_inc is 0 outside READ.
- Reset mid-operation: return to CLEAR, full CLEAR_CYCLES wait again, pending start discarded.
- Pass counter is 8-bit and compared for equality with the latched passes. No wrap is possible, since passes ≤255.

Decomposition:
- Shared package: state encoding and the spad word field positions (DATA_LSB=5, CNT_W=5, word width 13), also used by the spad and its decoders.
- Sub-module pass_counter: an 8-bit counter with clear, increment, and terminal-count flag, reused by later-data spad sequencers.
- FSM and handshake logic stay in the top.

Test Plan:
- Reset, cfg_start at cycle 10 → spad_write_en stays 0 until cycle 100 after reset; start honoured, LOAD entered first IDLE cycle.
- Load 3 words {0x0A1,0x142,0x1E3} then 0; passes=2, mac_ready=1 → 6 mac_valid beats in order A1,142,1E3,A1,142,1E3; mac_pass_end twice; done 1 cycle after 2nd pass_end.
- Same vector, mac_ready toggled 1010… → each word held until accepted; index_inc only on accepted cycles; output order unchanged.
- passes=0 → behaves as 1: one pass_end, then done.
- Empty vector (only terminator), passes=3 → 3 consecutive pass_end pulses, no mac_valid, then done.
- Reset asserted mid-READ → all outputs 0, busy=1, CLEAR restarts; a subsequent cfg_start replays correctly after 100 cycles.
